// File: rtl/count_seq_pkg.sv
// Shared state encoding and default sizes for the lab run controller.
package count_seq_pkg;

    localparam int unsigned WIDTH_DEF  = 4;
    localparam int unsigned RUNS_W_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_BAD   = 2'd3
    } state_t;

endpackage

// File: rtl/cnt_core.sv
// Plain up-counter with enable and synchronous clear; clear wins over enable.
module cnt_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Run controller: latches a terminal value on start, sequences one-shot or
// auto-reload runs with pause/abort, pulses done per terminal and tallies runs.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned RUNS_W = RUNS_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  target,
    input  logic              auto_reload,
    input  logic              pause,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [RUNS_W-1:0] run_cnt,
    output logic [1:0]        state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] tgt_q;
    logic             mode_q;
    logic             active;
    logic             terminal;
    logic             start_ok;
    logic             start_bad;
    logic             en;
    logic             clr;

    cnt_core #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (clr),
        .count (count)
    );

    // Priority abort > pause > terminal > increment is folded into these qualifiers.
    always_comb begin
        active    = (state_q == S_RUN) || (state_q == S_PAUSE);
        terminal  = active && !abort && !pause && (count == tgt_q);
        start_ok  = (state_q == S_IDLE) && start && !abort && (target != '0);
        start_bad = (state_q == S_IDLE) && start && !abort && (target == '0);
        en        = active && !abort && !pause && !terminal;
        clr       = terminal || (active && abort) || start_ok || (state_q == S_BAD);

        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (terminal) begin
                    state_d = mode_q ? S_RUN : S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tgt_q   <= '0;
            mode_q  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            run_cnt <= '0;
        end else begin
            state_q <= state_d;
            done    <= terminal;
            err     <= start_bad;
            if (start_ok) begin
                tgt_q  <= target;
                mode_q <= auto_reload;
            end
            if (terminal) begin
                run_cnt <= run_cnt + RUNS_W'(1);
            end
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl: directed scenarios plus random
// stimulus, all compared against a cycle-level model of the run rules.
module tb_count_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] target;
    logic       auto_reload;
    logic       pause;
    logic       abort;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] run_cnt;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    // reference model: 0 idle, 1 running, 2 paused
    int m_state, m_count, m_tgt, m_runs;
    bit m_mode, m_done, m_err;

    count_seq_ctrl #(.WIDTH(4), .RUNS_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .target      (target),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .run_cnt     (run_cnt),
        .state       (state)
    );

    always #5 clk = ~clk;

    logic [12:0] sig;
    assign sig = {state, busy, done, err, run_cnt, count};

    function automatic logic [12:0] exp_sig();
        return {2'(m_state), 1'(m_state != 0), m_done, m_err, 4'(m_runs), 4'(m_count)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_tgt = 0; m_runs = 0;
        m_mode = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit nd, ne;
        nd = 0; ne = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_state == 0) begin
            if (start && !abort) begin
                if (target != 0) begin
                    m_tgt = int'(target); m_mode = auto_reload; m_count = 0; m_state = 1;
                end else begin
                    ne = 1;
                end
            end
        end else if (abort) begin
            m_state = 0; m_count = 0;
        end else if (pause) begin
            m_state = 2;
        end else if (m_count == m_tgt) begin
            m_count = 0; nd = 1; m_runs = (m_runs + 1) % 16;
            m_state = m_mode ? 1 : 0;
        end else begin
            m_count = m_count + 1; m_state = 1;
        end
        m_done = nd; m_err = ne;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet();
        start = 0; pause = 0; abort = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        quiet(); target = 0; auto_reload = 0;
        reset = 1;
        #1;
        cycle();
        checks++;
        if (sig !== 13'd0) begin
            errors++; $display("FAIL reset_state got %h want 0", sig);
        end
        reset = 0;
        cycle();
        checks++;
        if (sig !== exp_sig()) begin
            errors++; $display("FAIL reset_idle got %h want %h", sig, exp_sig());
        end
    endtask

    task automatic test_one_shot();
        logic [3:0] seq [4] = '{4'd1, 4'd2, 4'd3, 4'd0};
        target = 3; auto_reload = 0; start = 1;
        cycle();
        start = 0;
        checks++;
        if (count !== 4'd0 || state !== 2'd1) begin
            errors++; $display("FAIL one_shot_launch count=%0d state=%0d want 0/1", count, state);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (count !== seq[i] || done !== (i == 3) || sig !== exp_sig()) begin
                errors++;
                $display("FAIL one_shot_seq step %0d count=%0d done=%b want %0d/%b (sig %h vs %h)",
                         i, count, done, seq[i], (i == 3), sig, exp_sig());
            end
        end
        cycle();
        checks++;
        if (done !== 1'b0 || state !== 2'd0 || run_cnt !== 4'd1) begin
            errors++; $display("FAIL one_shot_end done=%b state=%0d runs=%0d want 0/0/1", done, state, run_cnt);
        end
    endtask

    task automatic test_auto_reload();
        int pulses = 0;
        do_reset();
        target = 9; auto_reload = 1; start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (done) pulses++;
            checks++;
            if (sig !== exp_sig()) begin
                errors++; $display("FAIL auto_reload_track cyc %0d got %h want %h", i, sig, exp_sig());
            end
        end
        checks++;
        if (pulses != 3 || run_cnt !== 4'd3 || busy !== 1'b1) begin
            errors++; $display("FAIL auto_reload_sum pulses=%0d runs=%0d busy=%b want 3/3/1", pulses, run_cnt, busy);
        end
        abort = 1;
        cycle();
        abort = 0;
    endtask

    task automatic test_pause();
        int e = 0;
        do_reset();
        target = 7; auto_reload = 0; start = 1;
        cycle();
        start = 0;
        repeat (4) begin cycle(); e++; end
        checks++;
        if (count !== 4'd4) begin
            errors++; $display("FAIL pause_pre count=%0d want 4", count);
        end
        pause = 1;
        for (int i = 0; i < 5; i++) begin
            cycle(); e++;
            checks++;
            if (count !== 4'd4 || state !== 2'd2) begin
                errors++; $display("FAIL pause_hold cyc %0d count=%0d state=%0d want 4/2", i, count, state);
            end
        end
        pause = 0;
        cycle(); e++;
        checks++;
        if (count !== 4'd5 || state !== 2'd1) begin
            errors++; $display("FAIL pause_release count=%0d state=%0d want 5/1", count, state);
        end
        while (!done && e < 40) begin cycle(); e++; end
        checks++;
        if (e != 13) begin
            errors++; $display("FAIL pause_done_delay edge=%0d want 13", e);
        end
    endtask

    task automatic test_abort();
        do_reset();
        target = 1; auto_reload = 0; start = 1;
        cycle();
        start = 0;
        repeat (2) cycle();
        target = 6; auto_reload = 1; start = 1;
        cycle();
        start = 0;
        repeat (6) cycle();
        checks++;
        if (count !== 4'd6) begin
            errors++; $display("FAIL abort_pre count=%0d want 6", count);
        end
        abort = 1;
        cycle();
        abort = 0;
        checks++;
        if (count !== 4'd0 || state !== 2'd0 || done !== 1'b0 || run_cnt !== 4'd1) begin
            errors++; $display("FAIL abort_terminal count=%0d state=%0d done=%b runs=%0d want 0/0/0/1",
                               count, state, done, run_cnt);
        end
        cycle();
        checks++;
        if (done !== 1'b0 || sig !== exp_sig()) begin
            errors++; $display("FAIL abort_after got %h want %h", sig, exp_sig());
        end
        start = 1; abort = 1; target = 5;
        cycle();
        quiet();
        checks++;
        if (state !== 2'd0 || err !== 1'b0) begin
            errors++; $display("FAIL abort_start state=%0d err=%b want 0/0", state, err);
        end
    endtask

    task automatic test_err_ignored();
        int e = 0;
        bit saw_err = 0;
        do_reset();
        target = 0; start = 1;
        cycle();
        start = 0;
        checks++;
        if (err !== 1'b1 || state !== 2'd0) begin
            errors++; $display("FAIL err_pulse err=%b state=%0d want 1/0", err, state);
        end
        cycle();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_width err=%b want 0", err);
        end
        target = 8; auto_reload = 0; start = 1;
        cycle();
        target = 2; auto_reload = 1;
        while (!done && e < 30) begin
            if (e == 5) start = 0;
            cycle(); e++;
            if (err) saw_err = 1;
        end
        checks++;
        if (e != 9 || saw_err || state !== 2'd0) begin
            errors++; $display("FAIL busy_start_ignored edge=%0d err_seen=%b state=%0d want 9/0/0", e, saw_err, state);
        end
        quiet();
    endtask

    task automatic test_reset_mid();
        do_reset();
        target = 9; auto_reload = 1; start = 1;
        cycle();
        start = 0;
        repeat (15) cycle();
        checks++;
        if (count !== 4'd5 || run_cnt !== 4'd1) begin
            errors++; $display("FAIL reset_mid_pre count=%0d runs=%0d want 5/1", count, run_cnt);
        end
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if (count !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || run_cnt !== 4'd0) begin
            errors++; $display("FAIL reset_mid_async count=%0d busy=%b done=%b runs=%0d want all 0",
                               count, busy, done, run_cnt);
        end
        model_reset();
        reset = 0;
        cycle();
    endtask

    task automatic test_wrap();
        int terms = 0;
        int guard = 0;
        do_reset();
        target = 1; auto_reload = 1; start = 1;
        cycle();
        start = 0;
        while (terms < 16 && guard < 100) begin
            cycle(); guard++;
            if (done) begin
                terms++;
                checks++;
                if (run_cnt !== 4'(terms)) begin
                    errors++; $display("FAIL wrap_count term %0d runs=%0d want %0d", terms, run_cnt, terms % 16);
                end
            end
        end
        checks++;
        if (terms != 16 || run_cnt !== 4'd0) begin
            errors++; $display("FAIL wrap_final terms=%0d runs=%0d want 16/0", terms, run_cnt);
        end
        abort = 1;
        cycle();
        abort = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            start       = ($urandom % 3) == 0;
            target      = 4'($urandom_range(0, 15));
            auto_reload = $urandom % 2;
            pause       = ($urandom % 6) == 0;
            abort       = ($urandom % 30) == 0;
            reset       = ($urandom % 250) == 0;
            cycle();
            checks++;
            if (sig !== exp_sig()) begin
                errors++; $display("FAIL random cyc %0d got %h want %h", i, sig, exp_sig());
            end
        end
        reset = 0;
        quiet();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_abort();
        test_err_ignored();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
